// File: rtl/blvds_pkg.sv
// Shared BLVDS line definitions: sync word, service word type codes and FSM state encoding.
// Used by both the transmitter and the receiver.
package blvds_pkg;

    localparam logic [17:0] SYNC_SEQ = 18'h3FE00;
    localparam logic [17:0] FILLER   = 18'h00000;
    localparam logic [15:0] MAX_SAMPLE_NUM = 16'd4087;

    localparam logic [2:0] TYPE_FH1 = 3'b000;
    localparam logic [2:0] TYPE_FH2 = 3'b001;
    localparam logic [2:0] TYPE_PH1 = 3'b010;
    localparam logic [2:0] TYPE_PH2 = 3'b011;
    localparam logic [2:0] TYPE_FE1 = 3'b100;
    localparam logic [2:0] TYPE_FE2 = 3'b101;
    localparam logic [2:0] TYPE_PE1 = 3'b110;
    localparam logic [2:0] TYPE_PE2 = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FRAME_HEAD,
        ST_PACK_WAIT,
        ST_PACK_HEAD,
        ST_DATA,
        ST_PACK_EPILOG,
        ST_FRAME_EPILOG,
        ST_GAP
    } blvdsState_t;

    function automatic logic [17:0] serviceWord(input logic [2:0] code, input logic [12:0] payload);
        return {2'b11, code, payload};
    endfunction

endpackage

// File: rtl/blvds_crc_acc.sv
// 18-bit wrapping sum accumulator with synchronous clear; CRC is the inverted low 16 bits.
// Clear and add in the same cycle restart the sum with the new word.
module blvds_crc_acc (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        clear,
    input  logic        add,
    input  logic [17:0] word,
    output logic [15:0] crc
);

    logic [17:0] acc;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            acc <= 18'd0;
        end else begin
            acc <= (clear ? 18'd0 : acc) + (add ? word : 18'd0);
        end
    end

    assign crc = ~acc[15:0];

endmodule

// File: rtl/blvds_transmitter.sv
// BLVDS frame transmitter: frames FIFO samples into packets with headers, epilogs and CRCs,
// emitting SYNC_SEQ between frames. State holds the word currently on the line.
module blvds_transmitter
    import blvds_pkg::*;
#(
    parameter logic [7:0] FRAME_GAP = 8'd110
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iSTART,
    input  logic [2:0]  iFORMAT,
    input  logic [7:0]  iPACK_NUM,
    input  logic [3:0]  iCHANNELS,
    input  logic [7:0]  iPACK_SIZE,
    input  logic [15:0] iSAMPLE_NUM,
    input  logic [15:0] iFIFO_Q,
    input  logic [11:0] iFIFO_USEDW,
    output logic        oRD_REQ,
    output logic [17:0] oDATA_BLVDS,
    output logic        oBUSY,
    output logic        oFRAME_DONE,
    output logic        oPARAM_ERROR
);

    blvdsState_t state, stateNext;
    logic        half, halfNext;
    logic [1:0]  frameCnt, frameCntNext;
    logic [7:0]  packDone, packDoneNext;
    logic [11:0] wordCnt, wordCntNext;
    logic [7:0]  gapCnt, gapCntNext;

    logic [7:0]  packNumL;
    logic [3:0]  channelsL;
    logic [7:0]  packSizeL;
    logic [15:0] sampleNumL;

    logic [17:0] dataNext;
    logic        rdNext, doneNext, errNext;
    logic        latchFields, goPacket, fifoReady;
    logic        pktClr, pktAdd, frmClr, frmAdd;
    logic [15:0] pktCrc, frmCrc;

    blvds_crc_acc uPktCrc (
        .iCLK (iCLK),
        .iRST (iRST),
        .clear(pktClr),
        .add  (pktAdd),
        .word (dataNext),
        .crc  (pktCrc)
    );

    blvds_crc_acc uFrmCrc (
        .iCLK (iCLK),
        .iRST (iRST),
        .clear(frmClr),
        .add  (frmAdd),
        .word (dataNext),
        .crc  (frmCrc)
    );

    assign fifoReady = ({5'd0, iFIFO_USEDW} >= ({1'b0, sampleNumL} + 17'd8));

    always_comb begin
        stateNext    = state;
        halfNext     = half;
        frameCntNext = frameCnt;
        packDoneNext = packDone;
        wordCntNext  = wordCnt;
        gapCntNext   = gapCnt;
        dataNext     = SYNC_SEQ;
        rdNext       = 1'b0;
        doneNext     = 1'b0;
        errNext      = 1'b0;
        latchFields  = 1'b0;
        goPacket     = 1'b0;
        pktClr       = 1'b0;
        pktAdd       = 1'b0;
        frmClr       = 1'b0;
        frmAdd       = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (iSTART) begin
                    if (iSAMPLE_NUM > MAX_SAMPLE_NUM) begin
                        errNext = 1'b1;
                    end else begin
                        latchFields  = 1'b1;
                        stateNext    = ST_FRAME_HEAD;
                        halfNext     = 1'b0;
                        packDoneNext = 8'd0;
                        dataNext     = serviceWord(TYPE_FH1, {iFORMAT, frameCnt, iPACK_NUM});
                        frmClr       = 1'b1;
                        frmAdd       = 1'b1;
                    end
                end
            end
            ST_FRAME_HEAD: begin
                if (!half) begin
                    halfNext = 1'b1;
                    dataNext = serviceWord(TYPE_FH2, {1'b0, channelsL, packSizeL});
                    frmAdd   = 1'b1;
                end else begin
                    goPacket = 1'b1;
                end
            end
            ST_PACK_WAIT: begin
                goPacket = 1'b1;
            end
            ST_PACK_HEAD: begin
                if (!half) begin
                    halfNext = 1'b1;
                    dataNext = serviceWord(TYPE_PH2, {5'd0, sampleNumL[7:0]});
                    pktAdd   = 1'b1;
                    frmAdd   = 1'b1;
                end else begin
                    stateNext   = ST_DATA;
                    dataNext    = {2'b00, iFIFO_Q};
                    rdNext      = 1'b1;
                    pktAdd      = 1'b1;
                    frmAdd      = 1'b1;
                    wordCntNext = sampleNumL[11:0] + 12'd7;
                end
            end
            ST_DATA: begin
                if (wordCnt == 12'd0) begin
                    stateNext = ST_PACK_EPILOG;
                    halfNext  = 1'b0;
                    dataNext  = serviceWord(TYPE_PE1, {5'd0, pktCrc[15:8]});
                    frmAdd    = 1'b1;
                end else begin
                    dataNext    = {2'b00, iFIFO_Q};
                    rdNext      = 1'b1;
                    pktAdd      = 1'b1;
                    frmAdd      = 1'b1;
                    wordCntNext = wordCnt - 12'd1;
                end
            end
            ST_PACK_EPILOG: begin
                if (!half) begin
                    halfNext = 1'b1;
                    dataNext = serviceWord(TYPE_PE2, {5'd0, pktCrc[7:0]});
                    frmAdd   = 1'b1;
                end else begin
                    // pack_num of 0 wraps the 8-bit count back to 0 after 256 packets
                    packDoneNext = packDone + 8'd1;
                    if (packDoneNext != packNumL) begin
                        goPacket = 1'b1;
                    end else begin
                        stateNext = ST_FRAME_EPILOG;
                        halfNext  = 1'b0;
                        dataNext  = serviceWord(TYPE_FE1, {5'd0, frmCrc[15:8]});
                    end
                end
            end
            ST_FRAME_EPILOG: begin
                if (!half) begin
                    halfNext = 1'b1;
                    dataNext = serviceWord(TYPE_FE2, {5'd0, frmCrc[7:0]});
                end else begin
                    doneNext     = 1'b1;
                    frameCntNext = frameCnt + 2'd1;
                    gapCntNext   = FRAME_GAP - 8'd1;
                    stateNext    = (FRAME_GAP == 8'd0) ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                if (gapCnt == 8'd0) begin
                    stateNext = ST_IDLE;
                end else begin
                    gapCntNext = gapCnt - 8'd1;
                end
            end
            default: stateNext = ST_IDLE;
        endcase

        // A zero-length wait goes straight to PH1 without a filler word
        if (goPacket) begin
            if (fifoReady) begin
                stateNext = ST_PACK_HEAD;
                halfNext  = 1'b0;
                dataNext  = serviceWord(TYPE_PH1, {packDoneNext[4:0], sampleNumL[15:8]});
                pktClr    = 1'b1;
                pktAdd    = 1'b1;
                frmAdd    = 1'b1;
            end else begin
                stateNext = ST_PACK_WAIT;
                dataNext  = FILLER;
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state        <= ST_IDLE;
            half         <= 1'b0;
            frameCnt     <= 2'd0;
            packDone     <= 8'd0;
            wordCnt      <= 12'd0;
            gapCnt       <= 8'd0;
            packNumL     <= 8'd0;
            channelsL    <= 4'd0;
            packSizeL    <= 8'd0;
            sampleNumL   <= 16'd0;
            oDATA_BLVDS  <= SYNC_SEQ;
            oRD_REQ      <= 1'b0;
            oBUSY        <= 1'b0;
            oFRAME_DONE  <= 1'b0;
            oPARAM_ERROR <= 1'b0;
        end else begin
            state        <= stateNext;
            half         <= halfNext;
            frameCnt     <= frameCntNext;
            packDone     <= packDoneNext;
            wordCnt      <= wordCntNext;
            gapCnt       <= gapCntNext;
            oDATA_BLVDS  <= dataNext;
            oRD_REQ      <= rdNext;
            oBUSY        <= (stateNext != ST_IDLE);
            oFRAME_DONE  <= doneNext;
            oPARAM_ERROR <= errNext;
            if (latchFields) begin
                packNumL   <= iPACK_NUM;
                channelsL  <= iCHANNELS;
                packSizeL  <= iPACK_SIZE;
                sampleNumL <= iSAMPLE_NUM;
            end
        end
    end

endmodule

// File: tb/tb_blvds_transmitter.sv
// Scoreboard bench for blvds_transmitter: stimulus pushes expected line words,
// a negedge monitor pops and compares every non-sync, non-filler word.
module tb_blvds_transmitter;

    localparam logic [17:0] SYNC = 18'h3FE00;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        iSTART = 1'b0;
    logic [2:0]  iFORMAT = '0;
    logic [7:0]  iPACK_NUM = '0;
    logic [3:0]  iCHANNELS = '0;
    logic [7:0]  iPACK_SIZE = '0;
    logic [15:0] iSAMPLE_NUM = '0;
    logic [15:0] iFIFO_Q = '0;
    logic [11:0] iFIFO_USEDW = '0;
    logic        oRD_REQ;
    logic [17:0] oDATA_BLVDS;
    logic        oBUSY;
    logic        oFRAME_DONE;
    logic        oPARAM_ERROR;

    int nChecks = 0;
    int nFails  = 0;
    int pe2Cnt  = 0;
    bit monEn   = 1'b0;
    logic [17:0] expQ[$];

    blvds_transmitter #(.FRAME_GAP(8'd110)) dut (
        .iCLK        (iCLK),
        .iRST        (iRST),
        .iSTART      (iSTART),
        .iFORMAT     (iFORMAT),
        .iPACK_NUM   (iPACK_NUM),
        .iCHANNELS   (iCHANNELS),
        .iPACK_SIZE  (iPACK_SIZE),
        .iSAMPLE_NUM (iSAMPLE_NUM),
        .iFIFO_Q     (iFIFO_Q),
        .iFIFO_USEDW (iFIFO_USEDW),
        .oRD_REQ     (oRD_REQ),
        .oDATA_BLVDS (oDATA_BLVDS),
        .oBUSY       (oBUSY),
        .oFRAME_DONE (oFRAME_DONE),
        .oPARAM_ERROR(oPARAM_ERROR)
    );

    always #5 iCLK = ~iCLK;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Independent frame model: builds the expected word list from the header fields
    task automatic pushFrame(input logic [2:0] fmt, input logic [1:0] fc, input logic [7:0] pn,
                             input logic [3:0] ch, input logic [7:0] ps, input logic [15:0] sn,
                             input logic [15:0] q);
        logic [17:0] fsum, psum, w;
        logic [15:0] crc;
        logic [4:0]  pc;
        int np;
        np = (pn == 8'd0) ? 256 : int'(pn);
        w = {2'b11, 3'b000, fmt, fc, pn};       expQ.push_back(w); fsum = w;
        w = {2'b11, 3'b001, 1'b0, ch, ps};      expQ.push_back(w); fsum = fsum + w;
        for (int p = 0; p < np; p++) begin
            pc = p[4:0];
            w = {2'b11, 3'b010, pc, sn[15:8]};  expQ.push_back(w); psum = w; fsum = fsum + w;
            w = {2'b11, 3'b011, 5'd0, sn[7:0]}; expQ.push_back(w); psum = psum + w; fsum = fsum + w;
            for (int i = 0; i < int'(sn) + 8; i++) begin
                w = {2'b00, q}; expQ.push_back(w); psum = psum + w; fsum = fsum + w;
            end
            crc = ~psum[15:0];
            w = {2'b11, 3'b110, 5'd0, crc[15:8]}; expQ.push_back(w); fsum = fsum + w;
            w = {2'b11, 3'b111, 5'd0, crc[7:0]};  expQ.push_back(w); fsum = fsum + w;
        end
        crc = ~fsum[15:0];
        expQ.push_back({2'b11, 3'b100, 5'd0, crc[15:8]});
        expQ.push_back({2'b11, 3'b101, 5'd0, crc[7:0]});
    endtask

    always @(negedge iCLK) begin
        logic [17:0] e;
        if (monEn && !iRST) begin
            if (oDATA_BLVDS != SYNC && !(oDATA_BLVDS == 18'h0 && !oRD_REQ)) begin
                if (expQ.size() == 0) begin
                    check("unexpected_word", 32'(oDATA_BLVDS), 32'(SYNC));
                end else begin
                    e = expQ.pop_front();
                    check("line_word", 32'(oDATA_BLVDS), 32'(e));
                    check("rd_req", 32'(oRD_REQ), 32'(e[17:16] == 2'b00));
                end
                if (oDATA_BLVDS[17:13] == 5'b11111) pe2Cnt++;
            end
        end
    end

    task automatic pulseStart();
        iSTART = 1'b1;
        @(negedge iCLK);
        iSTART = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        int n = 0;
        while (!oFRAME_DONE && n < budget) begin
            @(negedge iCLK);
            n++;
        end
        check("frame_done_seen", 32'(oFRAME_DONE), 32'd1);
    endtask

    task automatic countGap(input bit pokeStart, output int len);
        len = 0;
        while (oBUSY && len < 300) begin
            if (pokeStart && len == 5) iSTART = 1'b1;
            if (len == 6) iSTART = 1'b0;
            len++;
            @(negedge iCLK);
        end
        iSTART = 1'b0;
    endtask

    initial begin
        int gapLen, bad, n;

        repeat (3) @(negedge iCLK);
        check("rst_data", 32'(oDATA_BLVDS), 32'(SYNC));
        check("rst_rd", 32'(oRD_REQ), 32'd0);
        check("rst_busy", 32'(oBUSY), 32'd0);
        check("rst_done", 32'(oFRAME_DONE), 32'd0);
        check("rst_err", 32'(oPARAM_ERROR), 32'd0);
        iRST = 1'b0;
        monEn = 1'b1;
        @(negedge iCLK);

        // Frame 1: hand-computed reference sequence
        iPACK_NUM = 8'd1; iSAMPLE_NUM = 16'd0; iFIFO_USEDW = 12'd8; iFIFO_Q = 16'h0000;
        expQ.push_back(18'h30001); expQ.push_back(18'h32000);
        expQ.push_back(18'h34000); expQ.push_back(18'h36000);
        for (int i = 0; i < 8; i++) expQ.push_back(18'h00000);
        expQ.push_back(18'h3C05F); expQ.push_back(18'h3E0FF);
        expQ.push_back(18'h3809E); expQ.push_back(18'h3A0A0);
        pe2Cnt = 0;
        pulseStart();
        check("f1_busy", 32'(oBUSY), 32'd1);
        waitDone(200);
        check("f1_queue_empty", 32'(expQ.size()), 32'd0);
        check("f1_pe2_count", 32'(pe2Cnt), 32'd1);
        countGap(1'b0, gapLen);
        check("f1_gap_len", 32'(gapLen), 32'd110);

        // Frame 2: three packets, counters 0..2
        iFORMAT = 3'd5; iPACK_NUM = 8'd3; iCHANNELS = 4'hA; iPACK_SIZE = 8'h10;
        iSAMPLE_NUM = 16'd2; iFIFO_Q = 16'h1234; iFIFO_USEDW = 12'd1000;
        pushFrame(3'd5, 2'd1, 8'd3, 4'hA, 8'h10, 16'd2, 16'h1234);
        pe2Cnt = 0;
        pulseStart();
        waitDone(300);
        check("f2_queue_empty", 32'(expQ.size()), 32'd0);
        check("f2_pe2_count", 32'(pe2Cnt), 32'd3);
        countGap(1'b0, gapLen);

        // Frame 3: filler while USEDW is one short, then PH1; start poked during GAP
        iFORMAT = 3'd0; iPACK_NUM = 8'd1; iCHANNELS = 4'h0; iPACK_SIZE = 8'h00;
        iSAMPLE_NUM = 16'd0; iFIFO_Q = 16'h0000; iFIFO_USEDW = 12'd7;
        pushFrame(3'd0, 2'd2, 8'd1, 4'h0, 8'h00, 16'd0, 16'h0000);
        pulseStart();
        @(negedge iCLK);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge iCLK);
            if (oDATA_BLVDS != 18'h0 || oRD_REQ) bad++;
        end
        check("filler_hold", 32'(bad), 32'd0);
        iFIFO_USEDW = 12'd8;
        @(negedge iCLK);
        check("ph1_after_usedw", 32'(oDATA_BLVDS), 32'h34000);
        waitDone(200);
        check("f3_queue_empty", 32'(expQ.size()), 32'd0);
        countGap(1'b1, gapLen);
        check("f3_gap_len", 32'(gapLen), 32'd110);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge iCLK);
            if (oBUSY || oDATA_BLVDS != SYNC) bad++;
        end
        check("gap_start_ignored", 32'(bad), 32'd0);

        // Reset in the middle of DATA
        monEn = 1'b0;
        iSAMPLE_NUM = 16'd20; iFIFO_USEDW = 12'd28; iFIFO_Q = 16'hBEEF;
        pulseStart();
        n = 0;
        while (!oRD_REQ && n < 50) begin
            @(negedge iCLK);
            n++;
        end
        check("reached_data", 32'(oRD_REQ), 32'd1);
        repeat (3) @(negedge iCLK);
        iRST = 1'b1;
        @(negedge iCLK);
        check("abort_data", 32'(oDATA_BLVDS), 32'(SYNC));
        check("abort_rd", 32'(oRD_REQ), 32'd0);
        check("abort_busy", 32'(oBUSY), 32'd0);
        iRST = 1'b0;
        expQ.delete();
        monEn = 1'b1;
        @(negedge iCLK);

        // Parameter error just above the limit
        iSAMPLE_NUM = 16'd4088;
        pulseStart();
        check("perr_pulse", 32'(oPARAM_ERROR), 32'd1);
        check("perr_busy", 32'(oBUSY), 32'd0);
        check("perr_data", 32'(oDATA_BLVDS), 32'(SYNC));
        @(negedge iCLK);
        check("perr_clear", 32'(oPARAM_ERROR), 32'd0);

        // Limit value accepted; frame counter restarted by the earlier reset
        iSAMPLE_NUM = 16'd4087; iFIFO_USEDW = 12'd0;
        expQ.push_back(18'h30001); expQ.push_back(18'h32000);
        pulseStart();
        check("limit_busy", 32'(oBUSY), 32'd1);
        check("limit_no_err", 32'(oPARAM_ERROR), 32'd0);
        repeat (10) @(negedge iCLK);
        check("limit_filler", 32'(oDATA_BLVDS), 32'h0);
        check("limit_queue_empty", 32'(expQ.size()), 32'd0);
        iRST = 1'b1;
        @(negedge iCLK);
        iRST = 1'b0;
        @(negedge iCLK);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
